// File: rtl/voice_match_scorer.sv
// rtl/voice_match_scorer.sv - template scoring sequencer and best-match tracker
//
// Walks the sample RAM and every template in the directory memory in lockstep,
// sums the per-word add_val from thresh_comp into a score per template, and
// reports the best-scoring template, its score and a match flag.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       begin a scoring pass (only sampled in IDLE)
//   add_val     comparator result for the word read on the previous cycle
//   rd_en       read strobe to both memories
//   ram_addr    sample word offset
//   dir_addr    template base + word offset into the directory memory
//   busy        high whenever a pass is in progress
//   done        one-cycle pulse in the cycle the results update
//   best_idx    index of the highest-scoring template
//   best_score  score of best_idx
//   match       best_score >= MIN_SCORE
module voice_match_scorer #(
    parameter int WORDS     = 1024,
    parameter int NUM_TMPL  = 4,
    parameter int MIN_SCORE = 2048,
    localparam int AW  = $clog2(WORDS),
    localparam int DAW = $clog2(NUM_TMPL * WORDS),
    localparam int SW  = $clog2(4 * WORDS + 1),
    localparam int TW  = (NUM_TMPL > 1) ? $clog2(NUM_TMPL) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     add_val,
    output logic           rd_en,
    output logic [AW-1:0]  ram_addr,
    output logic [DAW-1:0] dir_addr,
    output logic           busy,
    output logic           done,
    output logic [TW-1:0]  best_idx,
    output logic [SW-1:0]  best_score,
    output logic           match
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  offset;
    logic [DAW-1:0] base;       // tmpl*WORDS, kept as a running sum
    logic [TW-1:0]  tmpl;
    logic [SW-1:0]  acc;
    logic [SW-1:0]  best_int;
    logic [TW-1:0]  best_tmpl;
    logic           v_q;        // add_val is valid this cycle

    logic           last_word;
    logic           last_tmpl;
    logic           take_cur;
    logic [SW-1:0]  win_score;
    logic [TW-1:0]  win_idx;

    assign last_word = (offset == AW'(WORDS - 1));
    assign last_tmpl = (tmpl == TW'(NUM_TMPL - 1));

    // Strict compare so ties keep the lower template index.
    assign take_cur  = (tmpl == '0) || (acc > best_int);
    assign win_score = take_cur ? acc : best_int;
    assign win_idx   = take_cur ? tmpl : best_tmpl;

    assign ram_addr = offset;
    assign dir_addr = base + DAW'(offset);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                rd_en = 1'b1;
                if (last_word) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = EVAL;
            EVAL:    state_nxt = last_tmpl ? DONE : RUN;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            offset     <= '0;
            base       <= '0;
            tmpl       <= '0;
            acc        <= '0;
            best_int   <= '0;
            best_tmpl  <= '0;
            v_q        <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
            match      <= 1'b0;
        end else begin
            state <= state_nxt;
            v_q   <= rd_en;

            if (v_q) acc <= acc + SW'(add_val);

            case (state)
                IDLE: begin
                    if (start) begin
                        offset    <= '0;
                        base      <= '0;
                        tmpl      <= '0;
                        acc       <= '0;
                        best_int  <= '0;
                        best_tmpl <= '0;
                    end
                end
                RUN: begin
                    offset <= last_word ? '0 : offset + 1'b1;
                end
                EVAL: begin
                    best_int  <= win_score;
                    best_tmpl <= win_idx;
                    if (last_tmpl) begin
                        // Results are loaded on the edge into DONE so they are
                        // already visible while done is high.
                        best_score <= win_score;
                        best_idx   <= win_idx;
                        match      <= (32'(win_score) >= MIN_SCORE);
                    end else begin
                        tmpl <= tmpl + 1'b1;
                        base <= base + DAW'(WORDS);
                        acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_match_scorer.sv
// tb/tb_voice_match_scorer.sv - scoreboard bench for voice_match_scorer
module tb_voice_match_scorer;

    localparam int WORDS     = 4;
    localparam int NUM_TMPL  = 3;
    localparam int MIN_SCORE = 8;
    localparam int N         = WORDS * NUM_TMPL;
    localparam int DONE_LAT  = NUM_TMPL * (WORDS + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] add_val = 3'd0;
    logic       rd_en;
    logic [1:0] ram_addr;
    logic [3:0] dir_addr;
    logic       busy;
    logic       done;
    logic [1:0] best_idx;
    logic [4:0] best_score;
    logic       match;

    voice_match_scorer #(
        .WORDS(WORDS), .NUM_TMPL(NUM_TMPL), .MIN_SCORE(MIN_SCORE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .add_val(add_val),
        .rd_en(rd_en), .ram_addr(ram_addr), .dir_addr(dir_addr),
        .busy(busy), .done(done), .best_idx(best_idx),
        .best_score(best_score), .match(match)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int score;
        int mt;
        int edge_at;
    } exp_t;

    int   tbl [N];        // comparator result per directory word
    exp_t sb[$];
    int   aq[$];
    int   checks = 0;
    int   failures = 0;
    int   ecount = 0;
    int   done_cnt = 0;
    int   rd_count = 0;
    int   held_idx = 0, held_score = 0, held_mt = 0;

    always @(posedge clk) ecount <= ecount + 1;

    // Memories + thresh_comp: result appears one cycle after the read strobe.
    always @(posedge clk) add_val <= rd_en ? 3'(tbl[dir_addr]) : 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: sum each template, first maximum wins.
    task automatic model(output int idx, output int score);
        int s;
        idx = 0;
        score = -1;
        for (int t = 0; t < NUM_TMPL; t++) begin
            s = 0;
            for (int w = 0; w < WORDS; w++) s += tbl[t*WORDS + w];
            if (s > score) begin
                score = s;
                idx = t;
            end
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops scoreboard entries when the DUT presents them.
    always @(negedge clk) begin
        exp_t e;
        int a;
        if (rst) begin
            held_idx = 0; held_score = 0; held_mt = 0;
            rd_count = 0;
        end else begin
            if (rd_en) begin
                rd_count++;
                chk("busy_during_read", 32'(busy), 1);
                if (aq.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    a = aq.pop_front();
                    chk("dir_addr", 32'(dir_addr), a);
                    chk("ram_addr", 32'(ram_addr), a % WORDS);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("best_idx", 32'(best_idx), e.idx);
                    chk("best_score", 32'(best_score), e.score);
                    chk("match", 32'(match), e.mt);
                    chk("done_cycle", ecount, e.edge_at);
                    chk("read_count", rd_count, N);
                    held_idx = e.idx; held_score = e.score; held_mt = e.mt;
                end
                rd_count = 0;
                done_cnt++;
            end else begin
                chk("hold_idx", 32'(best_idx), held_idx);
                chk("hold_score", 32'(best_score), held_score);
                chk("hold_match", 32'(match), held_mt);
            end
        end
    end

    task automatic push_pass();
        exp_t e;
        int idx, score;
        model(idx, score);
        e.idx = idx;
        e.score = score;
        e.mt = (score >= MIN_SCORE) ? 1 : 0;
        e.edge_at = ecount + DONE_LAT;
        sb.push_back(e);
        for (int i = 0; i < N; i++) aq.push_back(i);
    endtask

    task automatic run_pass(input bit repulse);
        int tgt;
        bit seen;
        tgt = done_cnt + 1;
        push_pass();
        start = 1'b1;
        wait_edges(1);
        start = 1'b0;
        if (repulse) begin
            wait_edges(4);          // now in cycle 5, mid-pass
            start = 1'b1;
            wait_edges(1);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            wait_edges(1);
            if (done_cnt >= tgt) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            sb.delete();
            aq.delete();
        end
        wait_edges(3);
        chk("idle_after_done", 32'(busy), 0);
        chk("queue_empty", aq.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_match"}, 32'(match), 0);
        chk({tag, "_score"}, 32'(best_score), 0);
        chk({tag, "_idx"}, 32'(best_idx), 0);
        chk({tag, "_dir_addr"}, 32'(dir_addr), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    endtask

    task automatic fill_all(input int v);
        for (int i = 0; i < N; i++) tbl[i] = v;
    endtask

    initial begin
        int mode, v;
        rst = 1'b1;
        start = 1'b0;
        fill_all(0);
        wait_edges(3);
        check_zero("reset");
        rst = 1'b0;
        wait_edges(2);

        // All templates identical to the sample.
        fill_all(4);
        run_pass(1'b0);

        // Template 1 strong match, others weak.
        fill_all(1);
        for (int w = 0; w < 3; w++) tbl[WORDS + w] = 4;
        run_pass(1'b0);

        // Weak everywhere: below threshold, done still pulses.
        fill_all(1);
        run_pass(1'b0);

        // start re-pulsed while busy must be ignored.
        fill_all(4);
        run_pass(1'b1);

        // Reset mid-pass: no done, everything zeroed next cycle.
        fill_all(2);
        for (int i = 0; i < N; i++) aq.push_back(i);
        start = 1'b1;
        wait_edges(1);
        start = 1'b0;
        wait_edges(6);              // cycle 7
        rst = 1'b1;
        wait_edges(1);              // cycle 8
        rst = 1'b0;
        aq.delete();
        check_zero("midrst");
        wait_edges(2);
        run_pass(1'b0);

        // Randomized tables, including forced ties.
        for (int p = 0; p < 16; p++) begin
            mode = $urandom_range(0, 2);
            for (int w = 0; w < WORDS; w++) begin
                v = $urandom_range(0, 4);
                for (int t = 0; t < NUM_TMPL; t++) begin
                    case (mode)
                        0:       tbl[t*WORDS + w] = $urandom_range(0, 4);
                        1:       tbl[t*WORDS + w] = v;
                        default: tbl[t*WORDS + w] = (t == 0) ? v : $urandom_range(0, 4);
                    endcase
                end
            end
            run_pass(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
